block_end_scanner: RTL and testbench

//   Scans WebAssembly bytecode forward from the body of an `if` (or `block`/`loop`) to find its

---
 rtl/block_end_scanner.sv | 178 +++++++++++++++++
 tb/tb_block_end_scanner.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_end_scanner.sv
// Forward scanner for WebAssembly bytecode: starting inside an if/block/loop body, finds the
// matching end (and a depth-0 else), skipping opcode immediates and tracking nesting depth.
module block_end_scanner #(
    parameter int unsigned MEM_DEPTH = 5,
    parameter int unsigned DEPTH_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [MEM_DEPTH:0]   start_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 else_found_o,
    output logic [MEM_DEPTH:0]   else_addr_o,
    output logic [MEM_DEPTH:0]   end_addr_o,
    output logic [MEM_DEPTH:0]   mem_addr_o,
    output logic [3:0]           mem_extra_o,
    input  logic [127:0]         mem_data_i,
    input  logic                 mem_error_i
);

    localparam int unsigned AW = MEM_DEPTH + 1;

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StDone, StError} state_e;
    typedef enum logic [1:0] {ModeOp, ModeLeb, ModeFixed} mode_e;

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 leb_two_q, leb_two_d;
    logic                 else_found_q, else_found_d;
    logic [AW-1:0]        else_addr_q, else_addr_d;
    logic [AW-1:0]        end_addr_q, end_addr_d;
    logic                 error_q, error_d;

    logic [7:0]           op;
    logic [3:0]           inc;
    logic [AW:0]          ptr_sum;
    logic                 fin;
    logic                 fail;
    logic                 unused_mem_data;

    assign op              = mem_data_i[7:0];
    assign unused_mem_data = ^mem_data_i[127:8];

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        ptr_d        = ptr_q;
        depth_d      = depth_q;
        leb_two_d    = leb_two_q;
        else_found_d = else_found_q;
        else_addr_d  = else_addr_q;
        end_addr_d   = end_addr_q;
        error_d      = error_q;
        inc          = 4'd1;
        fin          = 1'b0;
        fail         = 1'b0;
        ptr_sum      = '0;

        unique case (state_q)
            StFetch: state_d = StWait;
            StWait: begin
                if (!mem_error_i) begin
                    unique case (mode_q)
                        ModeFixed: mode_d = ModeOp;
                        // leb_two marks a second LEB128 still to skip after the current one
                        ModeLeb: begin
                            if (!op[7]) begin
                                if (leb_two_q) leb_two_d = 1'b0;
                                else           mode_d    = ModeOp;
                            end
                        end
                        default: begin
                            case (op) inside
                                [8'h02:8'h04]: begin
                                    if (&depth_q) begin
                                        fail = 1'b1;
                                    end else begin
                                        depth_d = depth_q + 1'b1;
                                        mode_d  = ModeFixed;
                                    end
                                end
                                8'h05: begin
                                    if (depth_q == '0) begin
                                        else_found_d = 1'b1;
                                        else_addr_d  = ptr_q;
                                    end
                                end
                                8'h0B: begin
                                    if (depth_q == '0) begin
                                        end_addr_d = ptr_q;
                                        fin        = 1'b1;
                                    end else begin
                                        depth_d = depth_q - 1'b1;
                                    end
                                end
                                8'h0E: fail = 1'b1;
                                8'h0C, 8'h0D, 8'h10, [8'h20:8'h24], 8'h41, 8'h42: begin
                                    mode_d    = ModeLeb;
                                    leb_two_d = 1'b0;
                                end
                                [8'h28:8'h3E]: begin
                                    mode_d    = ModeLeb;
                                    leb_two_d = 1'b1;
                                end
                                8'h3F, 8'h40: mode_d = ModeFixed;
                                8'h43: inc = 4'd5;
                                8'h44: inc = 4'd9;
                                default: ;
                            endcase
                        end
                    endcase
                end

                ptr_sum = {1'b0, ptr_q} + (AW+1)'(inc);
                if (mem_error_i || fail || (!fin && ptr_sum[AW])) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else if (fin) begin
                    state_d = StDone;
                end else begin
                    ptr_d   = ptr_sum[AW-1:0];
                    state_d = StFetch;
                end
            end
            default: begin
                // StIdle, StDone and StError all accept a new start
                state_d = StIdle;
                if (start_i) begin
                    state_d      = StFetch;
                    ptr_d        = start_addr_i;
                    depth_d      = '0;
                    mode_d       = ModeOp;
                    leb_two_d    = 1'b0;
                    else_found_d = 1'b0;
                    error_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            mode_q       <= ModeOp;
            ptr_q        <= '0;
            depth_q      <= '0;
            leb_two_q    <= 1'b0;
            else_found_q <= 1'b0;
            else_addr_q  <= '0;
            end_addr_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            ptr_q        <= ptr_d;
            depth_q      <= depth_d;
            leb_two_q    <= leb_two_d;
            else_found_q <= else_found_d;
            else_addr_q  <= else_addr_d;
            end_addr_q   <= end_addr_d;
            error_q      <= error_d;
        end
    end

    assign busy_o       = (state_q == StFetch) || (state_q == StWait);
    assign done_o       = (state_q == StDone);
    assign error_o      = error_q;
    assign else_found_o = else_found_q;
    assign else_addr_o  = else_addr_q;
    assign end_addr_o   = end_addr_q;
    assign mem_addr_o   = (state_q == StFetch) ? ptr_q : '0;
    assign mem_extra_o  = 4'd0;

endmodule

// File: tb/tb_block_end_scanner.sv
// Bench for block_end_scanner: directed bytecode cases plus random programs checked against
// a byte-level interpreter of the scan rules.
module tb_block_end_scanner;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   start_addr;
    logic         busy, done, error, else_found;
    logic [5:0]   else_addr, end_addr, mem_addr;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data;
    logic         mem_err;

    logic [7:0]   rom [64];
    int           ub = 63;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    block_end_scanner #(.MEM_DEPTH(5), .DEPTH_W(8)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .start_addr_i (start_addr),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .else_found_o (else_found),
        .else_addr_o  (else_addr),
        .end_addr_o   (end_addr),
        .mem_addr_o   (mem_addr),
        .mem_extra_o  (mem_extra),
        .mem_data_i   (mem_data),
        .mem_error_i  (mem_err)
    );

    // Registered ROM: data and bound flag valid one cycle after the address
    always @(posedge clk) begin
        mem_data <= {120'd0, rom[mem_addr]};
        mem_err  <= (int'(mem_addr) > ub);
    end

    task automatic load(input int s, input logic [127:0] v, input int n);
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        for (int i = 0; i < n; i++) rom[s + i] = v[(n - 1 - i) * 8 +: 8];
        ub = 63;
    endtask

    // Interprets the bytes from s; returns what a correct scan must report
    task automatic model_scan(input int s, output bit m_err, output int m_end, output bit m_ef,
                              output int m_ea, output int m_reads);
        int p, d, leb, fix, inc;
        logic [7:0] b;
        p = s; d = 0; leb = 0; fix = 0;
        m_err = 0; m_end = 0; m_ef = 0; m_ea = 0; m_reads = 0;
        forever begin
            if (m_reads >= 200) begin m_err = 1; return; end
            m_reads++;
            if (p > ub) begin m_err = 1; return; end
            b = rom[p];
            inc = 1;
            if (fix > 0) fix--;
            else if (leb > 0) begin
                if (!b[7]) leb--;
            end else begin
                if (b >= 8'h02 && b <= 8'h04) begin
                    if (d == 255) begin m_err = 1; return; end
                    d++; fix = 1;
                end else if (b == 8'h05) begin
                    if (d == 0) begin m_ef = 1; m_ea = p; end
                end else if (b == 8'h0B) begin
                    if (d == 0) begin m_end = p; return; end
                    d--;
                end else if (b == 8'h0E) begin
                    m_err = 1; return;
                end else if (b inside {8'h0C, 8'h0D, 8'h10, [8'h20:8'h24], 8'h41, 8'h42}) leb = 1;
                else if (b >= 8'h28 && b <= 8'h3E) leb = 2;
                else if (b == 8'h3F || b == 8'h40) fix = 1;
                else if (b == 8'h43) inc = 5;
                else if (b == 8'h44) inc = 9;
            end
            if (p + inc > 63) begin m_err = 1; return; end
            p += inc;
        end
    endtask

    // Starts a scan and counts edges after the start edge until done or error (bounded).
    // poke>0 re-asserts start with another address at that cycle.
    task automatic run_scan(input int s, input int poke, output int cyc, output bit saw_done,
                            output bit saw_err);
        @(negedge clk);
        start = 1'b1; start_addr = 6'(s);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0; saw_done = 0; saw_err = 0;
        while (cyc < 400 && !saw_done && !saw_err) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) saw_done = 1;
            if (error) saw_err = 1;
            if (cyc == poke) begin start = 1'b1; start_addr = 6'd20; end
            else start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, error, else_found} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=0000", {busy, done, error, else_found});
        end
        checks++;
        if ({else_addr, end_addr, mem_addr, mem_extra} !== 22'd0) begin
            failures++;
            $display("FAIL reset_addrs got=%h/%h/%h/%h want=0", else_addr, end_addr, mem_addr, mem_extra);
        end
    endtask

    task automatic test_simple();
        int cyc; bit sd, se;
        load(4, 128'h41_03_0B, 3);
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!sd || cyc != 6) begin failures++; $display("FAIL simple_latency got=%0d done=%0b want=6", cyc, sd); end
        checks++;
        if (end_addr !== 6'd6 || else_found !== 1'b0) begin
            failures++; $display("FAIL simple_end got=%0d ef=%0b want=6 ef=0", end_addr, else_found);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL simple_busy got=%0b want=0", busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%0b want=0", done); end
    endtask

    task automatic test_else();
        int cyc; bit sd, se;
        load(4, 128'h41_01_05_41_02_0B, 6);
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!sd || else_found !== 1'b1 || else_addr !== 6'd6 || end_addr !== 6'd9) begin
            failures++;
            $display("FAIL else_case got done=%0b ef=%0b ea=%0d end=%0d want 1 1 6 9", sd, else_found, else_addr, end_addr);
        end
    endtask

    task automatic test_nested();
        int cyc; bit sd, se;
        load(4, 128'h04_40_05_0B_41_80_01_0B, 8);
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!sd || else_found !== 1'b0 || end_addr !== 6'd11) begin
            failures++;
            $display("FAIL nested got done=%0b ef=%0b end=%0d want 1 0 11", sd, else_found, end_addr);
        end
        checks++;
        if (cyc != 16) begin failures++; $display("FAIL nested_latency got=%0d want=16", cyc); end
    endtask

    task automatic test_f64();
        int cyc; bit sd, se;
        load(4, 128'h44_0B_0B_0B_0B_0B_0B_0B_0B_0B, 10);
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!sd || end_addr !== 6'd13) begin
            failures++; $display("FAIL f64_end got done=%0b end=%0d want 1 13", sd, end_addr);
        end
        checks++;
        if (cyc != 4) begin failures++; $display("FAIL f64_latency got=%0d want=4", cyc); end
    endtask

    task automatic test_errors();
        int cyc; bit sd, se;
        load(4, 128'h0E_0B, 2);
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!se || sd || busy) begin failures++; $display("FAIL err_brtable got err=%0b done=%0b want 1 0", se, sd); end

        load(4, 128'h41_03_0B, 3);
        ub = 5;
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!se || sd) begin failures++; $display("FAIL err_bound got err=%0b done=%0b want 1 0", se, sd); end
        ub = 63;

        load(4, 128'h01, 1);
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!se || sd) begin failures++; $display("FAIL err_wrap got err=%0b done=%0b want 1 0", se, sd); end
        @(negedge clk);
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b want=1", error); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit sd, se;
        load(4, 128'h41_01_05_41_02_0B, 6);
        @(negedge clk);
        start = 1'b1; start_addr = 6'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, error, else_found} !== 4'b0 || {else_addr, end_addr, mem_addr} !== 18'd0) begin
            failures++;
            $display("FAIL reset_mid got b=%0b d=%0b e=%0b ef=%0b ea=%0d end=%0d ma=%0d want all 0",
                     busy, done, error, else_found, else_addr, end_addr, mem_addr);
        end
        run_scan(4, 0, cyc, sd, se);
        checks++;
        if (!sd || cyc != 12 || else_addr !== 6'd6 || end_addr !== 6'd9) begin
            failures++;
            $display("FAIL reset_mid_rerun got done=%0b cyc=%0d ea=%0d end=%0d want 1 12 6 9", sd, cyc, else_addr, end_addr);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit sd, se;
        load(4, 128'h41_03_0B, 3);
        rom[20] = 8'h0B;
        run_scan(4, 2, cyc, sd, se);
        checks++;
        if (!sd || cyc != 6 || end_addr !== 6'd6) begin
            failures++; $display("FAIL start_while_busy got done=%0b cyc=%0d end=%0d want 1 6 6", sd, cyc, end_addr);
        end
        run_scan(20, 0, cyc, sd, se);
        checks++;
        if (!sd || cyc != 2 || end_addr !== 6'd20) begin
            failures++; $display("FAIL back_to_back got done=%0b cyc=%0d end=%0d want 1 2 20", sd, cyc, end_addr);
        end
    endtask

    task automatic put(inout int p, input logic [7:0] b);
        if (p < 64) rom[p] = b;
        p++;
    endtask

    task automatic put_leb(inout int p);
        int n;
        logic [7:0] b;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 127));
            if (i < n - 1) b[7] = 1'b1;
            put(p, b);
        end
    endtask

    task automatic test_random();
        int s, p, d, cyc, m_end, m_ea, m_reads;
        bit sd, se, m_err, m_ef;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
            ub = 63;
            s = $urandom_range(0, 10);
            p = s; d = 0;
            for (int n = 0; n < 12; n++) begin
                case ($urandom_range(0, 8))
                    0: put(p, 8'h01);
                    1: begin put(p, 8'h41); put_leb(p); end
                    2: begin put(p, 8'h28); put_leb(p); put_leb(p); end
                    3: begin put(p, 8'h04); put(p, 8'h40); d++; end
                    4: if (d > 0) begin put(p, 8'h0B); d--; end
                    5: put(p, 8'h05);
                    6: begin put(p, 8'h43); p += 4; end
                    7: begin put(p, 8'h44); p += 8; end
                    default: begin put(p, 8'h3F); put(p, 8'($urandom)); end
                endcase
            end
            while (d > 0) begin put(p, 8'h0B); d--; end
            put(p, 8'h0B);
            model_scan(s, m_err, m_end, m_ef, m_ea, m_reads);
            run_scan(s, 0, cyc, sd, se);
            checks++;
            if (se !== m_err || sd === m_err) begin
                failures++; $display("FAIL rand%0d_outcome got done=%0b err=%0b want err=%0b", it, sd, se, m_err);
            end
            if (!m_err) begin
                checks++;
                if (cyc != 2 * m_reads) begin
                    failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, cyc, 2 * m_reads);
                end
                checks++;
                if (int'(end_addr) != m_end || else_found !== m_ef || (m_ef && int'(else_addr) != m_ea)) begin
                    failures++;
                    $display("FAIL rand%0d_addrs got end=%0d ef=%0b ea=%0d want end=%0d ef=%0b ea=%0d",
                             it, end_addr, else_found, else_addr, m_end, m_ef, m_ea);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_else();
        test_nested();
        test_f64();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
